// File: rtl/mem_access_sequencer.sv
// Arbitrates instruction fetch, data load and data store onto one waitrequest-style memory bus.
// Optional BUS_TIMEOUT_EN abandons stalled transfers after TIMEOUT_CYCLES and raises a sticky bus_error.
module mem_access_sequencer #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              load_req,
    input  logic              store_req,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic [3:0]        data_be,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic              load_valid,
    output logic [DATA_W-1:0] load_data,
    output logic              store_done,
    output logic              req_overrun,
    output logic              busy,
    output logic [ADDR_W-1:0] bus_address,
    output logic              bus_read,
    output logic              bus_write,
    output logic [DATA_W-1:0] bus_writedata,
    output logic [3:0]        bus_byteenable,
    input  logic [DATA_W-1:0] bus_readdata,
    input  logic              bus_waitrequest,
    output logic              bus_error
);

    // Handshake: a transfer is presented while bus_read/bus_write is 1 and completes on the
    // first rising edge at which bus_waitrequest is 0; all bus fields are held until then.

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
    typedef enum logic [1:0] {T_F, T_L, T_S} xfer_t;

    state_t state, state_next;
    xfer_t  cur_type;

    logic              pend_f, pend_l, pend_s;
    logic [ADDR_W-1:0] f_addr, l_addr, s_addr;
    logic [3:0]        l_be, s_be;
    logic [DATA_W-1:0] s_wdata;
    logic              overrun_q;

    logic grant_s, grant_l, grant_f, grant_any;
    logic xfer_done, timeout;
    logic take_f, take_l, take_s, overrun;

    assign grant_s   = (state == IDLE) && pend_s;
    assign grant_l   = (state == IDLE) && !pend_s && pend_l;
    assign grant_f   = (state == IDLE) && !pend_s && !pend_l && pend_f;
    assign grant_any = grant_s || grant_l || grant_f;
    assign xfer_done = (state == XFER) && !bus_waitrequest;

    // A request is dropped if its flag is already set or the same type is on the bus;
    // a load colliding with a store always loses.
    assign take_f  = fetch_req && !pend_f && !((state == XFER) && (cur_type == T_F));
    assign take_s  = store_req && !pend_s && !((state == XFER) && (cur_type == T_S));
    assign take_l  = load_req && !store_req && !pend_l && !((state == XFER) && (cur_type == T_L));
    assign overrun = (fetch_req && !take_f) || (store_req && !take_s) || (load_req && !take_l);

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;
    logic             err_q;

    assign timeout   = (state == XFER) && bus_waitrequest && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_error = err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state != XFER)
                to_cnt <= '0;
            else if (bus_waitrequest)
                to_cnt <= to_cnt + 1'b1;
            if (timeout)
                err_q <= 1'b1;
        end
    end
`else
    assign timeout   = 1'b0;
    assign bus_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_any) state_next = XFER;
            XFER: begin
                if (xfer_done)    state_next = DONE;
                else if (timeout) state_next = IDLE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_f         <= 1'b0;
            pend_l         <= 1'b0;
            pend_s         <= 1'b0;
            f_addr         <= '0;
            l_addr         <= '0;
            s_addr         <= '0;
            l_be           <= '0;
            s_be           <= '0;
            s_wdata        <= '0;
            overrun_q      <= 1'b0;
            cur_type       <= T_F;
            bus_address    <= '0;
            bus_read       <= 1'b0;
            bus_write      <= 1'b0;
            bus_writedata  <= '0;
            bus_byteenable <= '0;
            instr          <= '0;
            load_data      <= '0;
        end else begin
            overrun_q <= overrun;

            if (take_f) begin
                pend_f <= 1'b1;
                f_addr <= fetch_addr;
            end else if (grant_f) begin
                pend_f <= 1'b0;
            end

            if (take_l) begin
                pend_l <= 1'b1;
                l_addr <= data_addr;
                l_be   <= data_be;
            end else if (grant_l) begin
                pend_l <= 1'b0;
            end

            if (take_s) begin
                pend_s  <= 1'b1;
                s_addr  <= data_addr;
                s_be    <= data_be;
                s_wdata <= data_wdata;
            end else if (grant_s) begin
                pend_s <= 1'b0;
            end

            if (grant_s) begin
                cur_type       <= T_S;
                bus_address    <= s_addr;
                bus_byteenable <= s_be;
                bus_writedata  <= s_wdata;
                bus_write      <= 1'b1;
            end else if (grant_l) begin
                cur_type       <= T_L;
                bus_address    <= l_addr;
                bus_byteenable <= l_be;
                bus_writedata  <= '0;
                bus_read       <= 1'b1;
            end else if (grant_f) begin
                cur_type       <= T_F;
                bus_address    <= f_addr;
                bus_byteenable <= 4'hF;
                bus_writedata  <= '0;
                bus_read       <= 1'b1;
            end else if (xfer_done || timeout) begin
                bus_read  <= 1'b0;
                bus_write <= 1'b0;
                if (xfer_done && (cur_type == T_F)) instr     <= bus_readdata;
                if (xfer_done && (cur_type == T_L)) load_data <= bus_readdata;
            end
        end
    end

    assign instr_valid = (state == DONE) && (cur_type == T_F);
    assign load_valid  = (state == DONE) && (cur_type == T_L);
    assign store_done  = (state == DONE) && (cur_type == T_S);
    assign req_overrun = overrun_q;
    assign busy        = (state != IDLE) || pend_f || pend_l || pend_s;

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
Shares the CPU's single memory bus port between instruction fetch, data load and data store, with a waitrequest handshake.
- Requests are single-cycle pulses, latched as pending.
- Grants are issued by fixed priority.
- Each bus transfer is held until the slave releases waitrequest.
- Completion pulses (instr_valid, load_valid, store_done) feed the control FSM, replacing ad-hoc end-of-instruction strobes.

Parameters:
ADDR_W, 32, bus and request address width
DATA_W, 32, bus data width
TIMEOUT_CYCLES, 255, max waitrequest cycles before bus_error (only with BUS_TIMEOUT_EN)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-low: state cleared on a rising clk edge while reset=0
fetch_req  in  1  one-cycle pulse, fetch from fetch_addr
fetch_addr  in  ADDR_W  PC, sampled with fetch_req
load_req  in  1  one-cycle pulse, read from data_addr
store_req  in  1  one-cycle pulse, write data_wdata to data_addr
data_addr  in  ADDR_W  sampled with load_req/store_req
data_wdata  in  DATA_W  sampled with store_req
data_be  in  4  byte enables, sampled with load_req/store_req
instr_valid  out  1  one-cycle pulse, instr holds fetched word
instr  out  DATA_W  last fetched instruction, held until the next fetch completes
load_valid  out  1  one-cycle pulse, load_data valid
load_data  out  DATA_W  last load result, held
store_done  out  1  one-cycle pulse, store accepted by slave
req_overrun  out  1  one-cycle pulse, a request was dropped
busy  out  1  state != IDLE or any pending flag set
bus_address  out  ADDR_W  memory address
bus_read  out  1  memory read strobe
bus_write  out  1  memory write strobe
bus_writedata  out  DATA_W  memory write data
bus_byteenable  out  4  memory byte enables
bus_readdata  in  DATA_W  memory read data
bus_waitrequest  in  1  slave stall
bus_error  out  1  sticky timeout flag (0 without BUS_TIMEOUT_EN)

Behaviour:
- Reset (reset=0 at edge):
  - State goes to IDLE; pending flags cleared.
  - All outputs 0, including instr, load_data and bus_address.
  - Any in-flight transfer is abandoned: bus_read/bus_write go to 0 after that edge regardless of waitrequest.
- Pending latches: three flags (F, L, S), each with captured address/data/be.
  - A request pulse sets its flag on the next edge.
  - A pulse arriving while the same flag is set, or while the same type is in flight, is dropped and raises req_overrun the next cycle.
  - load_req and store_req in the same cycle: the store is latched, the load is dropped, req_overrun pulses.
- States: IDLE, XFER, DONE.
- IDLE:
  - If any flag is set, grant by priority S > L > F; the data access of the current instruction precedes the next fetch.
  - The granted flag is cleared and its address, be and wdata are driven onto the bus registers.
  - bus_read or bus_write is asserted from the next cycle; state goes to XFER.
  - A request pulse arriving in the same cycle as the grant edge is latched, not granted; earliest grant is one cycle later.
- XFER:
  - Strobe and bus fields are held constant while bus_waitrequest=1.
  - In the first cycle with bus_waitrequest=0, the transfer completes:
    - bus_readdata is captured into instr or load_data;
    - the strobe drops at the next edge;
    - state goes to DONE.
- DONE:
  - Exactly one of instr_valid/load_valid/store_done is 1 for one cycle.
  - Next state is IDLE.
- Latency:
  - Minimum request pulse to completion pulse = 4 cycles (latch, grant, XFER with waitrequest=0, DONE).
  - Each waitrequest cycle adds 1.
- Outputs: bus_read and bus_write are never both 1; at most one transfer is outstanding.
- busy: combinational from state and flags.

Optional Feature:
BUS_TIMEOUT_EN
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering XFER and increments each XFER cycle with waitrequest=1.
  - On reaching TIMEOUT_CYCLES, the transfer is abandoned: strobe drops, no completion pulse, state returns to IDLE.
  - bus_error is set and held until reset; pending flags are kept.
- Undefined: no counter; XFER waits indefinitely; bus_error is tied to 0.

Test Plan:
- Fetch, no wait: fetch_req with fetch_addr=0xBFC00000, readdata=0x24020005 -> bus_read high 1 cycle at 0xBFC00000; instr_valid 4 cycles after the request; instr=0x24020005.
- Load with 3 waitrequest cycles: load_req data_addr=0x00001000, readdata=0xDEADBEEF -> bus fields stable for 4 cycles; load_valid at cycle 7; load_data=0xDEADBEEF.
- Simultaneous fetch_req and store_req (addr 0x2000, wdata 0x12345678, be=0xF) -> store on bus first, store_done, then fetch; bus_write and bus_read never overlap.
- Overrun: second fetch_req while a fetch is in XFER -> req_overrun pulse; exactly one instr_valid.
- Reset during XFER with waitrequest=1 -> bus_read=0 and busy=0 at the next edge; no completion pulse; all outputs 0.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, waitrequest stuck at 1 -> strobe drops after 8 cycles; bus_error=1 sticky; no load_valid.
